// File: rtl/cpsr_cond_unit.sv
// cpsr_cond_unit: NZCV flag register with forwarded condition evaluation for ID and registered pass bit for EX.
module cpsr_cond_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic       stall,
    input  logic       flush,
    input  logic [3:0] id_cond,
    input  logic       ex_valid,
    input  logic       ex_s_bit,
    input  logic [3:0] ex_alu_op,
    input  logic       alu_n,
    input  logic       alu_z,
    input  logic       alu_c,
    input  logic       alu_v,
    input  logic       shifter_c,
    output logic [3:0] flags,
    output logic       alu_cin,
    output logic       id_cond_pass,
    output logic       ex_cond_pass,
    output logic       flags_wr
);
    logic       is_test;
    logic       is_arith;
    logic [3:0] next_flags;
    logic       n, z, c, v;

    // TST/TEQ/CMP/CMN (8..11) set flags regardless of the S bit
    assign is_test  = ex_alu_op[3:2] == 2'b10;
    assign is_arith = (ex_alu_op[3:1] inside {3'd1, 3'd2, 3'd3, 3'd5});
    assign flags_wr = ex_valid & ex_cond_pass & ~stall & (ex_s_bit | is_test);
    assign next_flags = !flags_wr ? flags :
                        is_arith  ? {alu_n, alu_z, alu_c, alu_v} :
                                    {alu_n, alu_z, shifter_c, flags[0]};
    assign {n, z, c, v} = next_flags;
    assign alu_cin = flags[1];

    // ID sees the flags EX is about to commit, so no bubble is needed
    always_comb begin
        id_cond_pass = 1'b0;
        case (id_cond)
            4'h0: id_cond_pass = z;
            4'h1: id_cond_pass = !z;
            4'h2: id_cond_pass = c;
            4'h3: id_cond_pass = !c;
            4'h4: id_cond_pass = n;
            4'h5: id_cond_pass = !n;
            4'h6: id_cond_pass = v;
            4'h7: id_cond_pass = !v;
            4'h8: id_cond_pass = c & !z;
            4'h9: id_cond_pass = !c | z;
            4'hA: id_cond_pass = n == v;
            4'hB: id_cond_pass = n != v;
            4'hC: id_cond_pass = !z & (n == v);
            4'hD: id_cond_pass = z | (n != v);
            4'hE: id_cond_pass = 1'b1;
            default: id_cond_pass = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flags        <= 4'b0000;
            ex_cond_pass <= 1'b0;
        end else begin
            flags        <= next_flags;
            ex_cond_pass <= flush ? 1'b0 : stall ? ex_cond_pass : id_cond_pass;
        end
    end
endmodule

// File: doc/cpsr_cond_unit.md
# cpsr_cond_unit

Execute-stage flag register and condition evaluator for the pipelined ARM-subset core. It sits directly downstream of the ALU and shifter. It captures their N/Z/C/V outputs when an instruction in EX updates the flags, and supplies the ALU carry-in. It also evaluates the 4-bit condition field of the instruction in ID against forwarded flags, and registers the pass/fail result into EX so later stages can squash failed instructions.

## Interface
- No parameters.
- clk  in  1  core clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- stall  in  1  freeze the ID and EX slots; no flag write, EX state held.
- flush  in  1  kill the instruction leaving ID; EX slot becomes a bubble on the next edge.
- id_cond  in  4  condition field (instr[31:28]) of the ID-stage instruction.
- ex_valid  in  1  EX slot holds a real instruction.
- ex_s_bit  in  1  S bit of the EX instruction.
- ex_alu_op  in  4  OPS code of the EX instruction (ALU encoding 0..15).
- alu_n, alu_z, alu_c, alu_v  in  1 each  ALU flag outputs for the EX instruction.
- shifter_c  in  1  shifter carry-out for the EX instruction.
- flags  out  4  {N,Z,C,V} register.
- alu_cin  out  1  equals flags[1] (C).
- id_cond_pass  out  1  combinational pass result for id_cond, using forwarded flags.
- ex_cond_pass  out  1  registered pass bit of the instruction now in EX.
- flags_wr  out  1  combinational; high in the cycle flags are written.

## Operation
- Flag write enable: flags_wr = ex_valid & ex_cond_pass & ~stall & (ex_s_bit | ex_alu_op in {8,9,10,11}).
  - TST, TEQ, CMP and CMN always set flags.
- Arithmetic ops {2,3,4,5,6,7,10,11}: next flags = {alu_n, alu_z, alu_c, alu_v}.
- Logical ops {0,1,8,9,12,13,14,15}: next flags = {alu_n, alu_z, shifter_c, V unchanged}.
- When flags_wr=0, next flags = flags.
- Forwarding: id_cond_pass evaluates against next flags, not the flags register. A flag-setting instruction in EX immediately followed by a conditional instruction needs no bubble.
- Condition table, using forwarded N, Z, C, V:
  - 0 EQ: Z
  - 1 NE: !Z
  - 2 CS: C
  - 3 CC: !C
  - 4 MI: N
  - 5 PL: !N
  - 6 VS: V
  - 7 VC: !V
  - 8 HI: C&!Z
  - 9 LS: !C|Z
  - A GE: N==V
  - B LT: N!=V
  - C GT: !Z&(N==V)
  - D LE: Z|(N!=V)
  - E AL: 1
  - F: 0 (never)
- ex_cond_pass register update, in priority order:
  - reset → 0
  - flush → 0
  - stall → hold
  - otherwise → id_cond_pass
- Flag register update, in priority order:
  - reset → 4'b0000
  - otherwise → next flags. Flush does not block the EX write; only stall blocks it.

## Timing
- Reset values: flags=0, alu_cin=0, ex_cond_pass=0. flags_wr=0 while ex_cond_pass=0.
- Latency:
  - id_cond_pass: 0 cycles (combinational).
  - ex_cond_pass: 1 cycle after ID.
  - flags: visible on the edge ending EX.
  - alu_cin: reflects the last committed C, so ADC/SBC/RSC in EX use the flags of the previous instruction.
- Simultaneous flush and stall: flush wins for ex_cond_pass (→0); flags are still not written, because stall is high.
- Reset mid-stall or mid-flush: reset wins; everything is cleared in the same edge.
- A failed-condition instruction in EX (ex_cond_pass=0) never writes flags, even with S=1.
- Back-to-back flag setters: each writes in its own EX cycle. The ID instruction always sees the youngest flags.

## Test plan
- Reset then idle: reset high for 2 cycles → flags=0000, ex_cond_pass=0, alu_cin=0; id_cond=E → id_cond_pass=1; id_cond=F → 0.
- Forwarding: EX holds CMP (op A, ex_valid=1, ex_cond_pass=1), alu_z=1 and other ALU flags 0; same cycle id_cond=0 (EQ).
  - Same cycle: id_cond_pass=1 and flags_wr=1.
  - Next cycle: flags=0100 and ex_cond_pass=1.
- Logical op carry source: flags=0001; EX holds MOVS (op D, S=1), alu_n=1, alu_z=0, alu_c=0, shifter_c=1 → flags become 1011 (V preserved, C from shifter).
- Condition fail suppresses write: flags=0100; ID holds an ADDS with cond NE → ex_cond_pass=0 next cycle. In that cycle, alu flags=1111 → flags_wr=0 and flags stay 0100.
- Stall/flush: CMP in EX with stall=1 → flags unchanged and ex_cond_pass held; release stall → write occurs. flush=1 with stall=1 → ex_cond_pass=0 next edge and flags unchanged.
- Signed conditions sweep: for each id_cond 0..F across all 16 NZCV values (forced via CMP writes), check id_cond_pass against the condition table. Examples: N=1,V=0 → GE=0, LT=1; Z=0,N=V=1 → GT=1.
